sum_accumulator_27bit: RTL and testbench
========================================

// Module: sum_accumulator_27bit
// PURPOSE
//  Downstream stage of the registered 26-bit square-root carry-select adder.
//  - Consumes its 27-bit registered sum through a valid/ready handshake.
//  - Accumulates ACC_COUNT consecutive sums.
//  - Presents each total on a held output handshake until it is taken.
//  - Supplies block-sum results to the datapath test harness.
// PARAMETERS
//  IN_WIDTH   27  width of incoming adder sum (unsigned)
//  ACC_WIDTH  32  accumulator / result width, >= IN_WIDTH
//  ACC_COUNT  16  samples per result, >= 1
//  CNT_WIDTH  5   sample counter width, $clog2(ACC_COUNT)+1
// PORTS
//  clk        in   1          single clock; all registers update on negedge clk, as the adder pipeline does
//  reset      in   1          synchronous, active-low; sampled on negedge clk
//  in_data    in   IN_WIDTH   adder sum
//  in_valid   in   1          in_data valid
//  in_ready   out  1          block can accept in_data
//  clear      in   1          abort current partial accumulation
//  out_data   out  ACC_WIDTH  accumulated result
//  out_valid  out  1          out_data valid
//  out_ready  in   1          consumer takes out_data
//  overflow   out  1          result saturated (SAT_EN only; else constant 0)
// BEHAVIOUR
//  - reset==0 at an edge:
//    - state=IDLE; acc=0; cnt=0; out_data=0; out_valid=0; overflow=0.
//    - in_ready=1 from the first edge after reset. Reset overrides every other input.
//  - States IDLE, ACCUM, HOLD. in_ready = (state!=HOLD), decoded directly from the state register.
//  - Transfer = in_valid & in_ready at an edge.
//    - acc_next = acc + zero-extended in_data (acc is 0 in IDLE); cnt_next = cnt+1.
//  - IDLE/ACCUM with transfer, cnt_next < ACC_COUNT: acc=acc_next, cnt=cnt_next, state=ACCUM.
//  - IDLE/ACCUM with transfer, cnt_next == ACC_COUNT:
//    - out_data=acc_next; out_valid=1; acc=0; cnt=0; state=HOLD.
//    - Result is visible after the edge that accepts the ACC_COUNT-th sample.
//  - IDLE/ACCUM, no transfer: acc and cnt hold; in_valid may gap arbitrarily.
//  - HOLD: in_ready=0; out_data/out_valid/overflow stable.
//    - out_ready=1 at an edge -> out_valid=0, state=IDLE.
//    - out_data keeps its last value after the handshake.
//  - Throughput: at least 1 idle cycle per result (HOLD is never bypassed).
//  - clear=1 in IDLE/ACCUM: acc=0, cnt=0, state=IDLE. Same-edge in_data is discarded (clear beats in_valid).
//  - clear=1 in HOLD: ignored; a pending result is always drained.
//  - ACC_COUNT==1: every transfer goes straight to HOLD.
//  - All arithmetic is unsigned, modulo 2^ACC_WIDTH unless SAT_EN.
// CONFIGURATION
//  SUM_ACC_SAT_EN defined:
//    - If acc + in_data > 2^ACC_WIDTH-1, acc becomes all-ones and a sticky ovf bit is set.
//    - Further adds keep all-ones.
//    - overflow is loaded with ovf together with out_data and held through HOLD.
//    - ovf is cleared on result hand-off, clear or reset.
//  SUM_ACC_SAT_EN undefined: acc wraps; overflow tied 0; no ovf register.
// STRUCTURE
//  - Shared include sum_acc_defs.vh:
//    - state encodings ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_HOLD=2'd2;
//    - default widths IN_WIDTH / ACC_WIDTH.
//  - One sub-module, sum_acc_counter: CNT_WIDTH sample counter with inc, clr and terminal-count (==ACC_COUNT-1) output.
//  - FSM, adder and output registers stay in the top module.
// TESTING
//  1 Reset: hold reset=0 for 2 edges with in_valid=1
//    -> out_valid=0, out_data=0, overflow=0, in_ready=1, no sample counted.
//  2 Defaults: 16 back-to-back 27'h7FFFFFF
//    -> out_data=32'h7FFFFFF0, out_valid=1 after the 16th edge, overflow=0.
//  3 Backpressure: hold out_ready=0 for 5 edges while in_valid=1
//    -> in_ready=0, out_data stable.
//    -> out_ready=1 gives out_valid=0 and in_ready=1 on the next edge.
//  4 Clear: after 3 samples of 27'd5, assert clear with in_valid=1 and in_data=27'd9,
//    then 16 samples of 27'd1 -> out_data=32'd16.
//  5 Gaps: ACC_COUNT=4, samples 1,2,3,4 with in_valid low 2 edges between each -> out_data=32'd10.
//  6 ACC_WIDTH=28, ACC_COUNT=4, 4x 27'h7FFFFFF:
//    -> SUM_ACC_SAT_EN: out_data=28'hFFFFFFF, overflow=1.
//    -> without it: out_data=28'hFFFFFFC, overflow=0.

Source files
------------

// File: rtl/sum_accumulator_27bit_pkg.sv
// -----------------------------------------------------------------------------
// sum_accumulator_27bit_pkg
//   Shared definitions for the sum accumulator block: FSM state encodings,
//   default datapath widths and a small state-decode helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package sum_accumulator_27bit_pkg;

  localparam int DEF_IN_WIDTH  = 27;
  localparam int DEF_ACC_WIDTH = 32;
  localparam int DEF_ACC_COUNT = 16;
  localparam int DEF_CNT_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Input side is open in every state except while a result is held.
  function automatic logic accepts_input(input state_t s);
    return (s != ST_HOLD);
  endfunction

endpackage

// File: rtl/sum_acc_counter.sv
// -----------------------------------------------------------------------------
// sum_acc_counter
//   Sample counter for the sum accumulator. Counts accepted samples and flags
//   the terminal count (ACC_COUNT-1) so the top can close a block.
//   Ports:
//     clk     in   clock, registers update on negedge
//     reset   in   synchronous active-low reset
//     i_inc   in   count one accepted sample
//     i_clr   in   return to zero (wins over i_inc)
//     o_tc    out  counter currently at ACC_COUNT-1
// -----------------------------------------------------------------------------
module sum_acc_counter #(
  parameter int ACC_COUNT = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_tc
);

  logic [CNT_WIDTH-1:0] r_cnt;

  // Sample count register; clear has priority over increment.
  always_ff @(negedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = (r_cnt == CNT_WIDTH'(ACC_COUNT - 1));

endmodule

// File: rtl/sum_accumulator_27bit.sv
// -----------------------------------------------------------------------------
// sum_accumulator_27bit
//   Accumulates ACC_COUNT consecutive sums from the registered 26-bit
//   carry-select adder and presents each block total on a held valid/ready
//   output until the consumer takes it.
//   Optional feature macro: SUM_ACC_SAT_EN (saturating accumulation with a
//   sticky overflow flag). Without it the accumulator wraps and overflow is 0.
//   Ports:
//     clk        in   clock; all registers update on negedge
//     reset      in   synchronous active-low reset
//     in_data    in   adder sum (unsigned)
//     in_valid   in   in_data valid
//     in_ready   out  block can accept in_data (decoded from state)
//     clear      in   abort current partial accumulation
//     out_data   out  accumulated result (holds after hand-off)
//     out_valid  out  out_data valid
//     out_ready  in   consumer takes out_data
//     overflow   out  result saturated
// -----------------------------------------------------------------------------
module sum_accumulator_27bit
  import sum_accumulator_27bit_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int ACC_COUNT = DEF_ACC_COUNT,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overflow
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_acc_nxt;
  logic [ACC_WIDTH-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 w_active;
  logic                 w_xfer;
  logic                 w_take;
  logic                 w_load;
  logic                 w_acc_clr;
  logic                 w_tc;

  assign w_active = accepts_input(r_state);
  assign in_ready = w_active;
  assign w_xfer   = in_valid & w_active;
  // clear beats a same-edge transfer: the sample is dropped
  assign w_take   = w_xfer & ~clear;
  assign w_load   = w_take & w_tc;
  // clear is only honoured while accepting; a held result always drains
  assign w_acc_clr = (w_active & clear) | w_load;

  sum_acc_counter #(
    .ACC_COUNT (ACC_COUNT),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_take),
    .i_clr (w_acc_clr),
    .o_tc  (w_tc)
  );

`ifdef SUM_ACC_SAT_EN
  logic [ACC_WIDTH:0] w_sum;
  logic               w_ovf_nxt;
  logic               r_ovf;
  logic               r_overflow;

  // One extra bit captures the carry out; once ovf is set the sum stays pinned.
  assign w_sum     = {1'b0, r_acc} + {1'b0, ACC_WIDTH'(in_data)};
  assign w_ovf_nxt = r_ovf | w_sum[ACC_WIDTH];
  assign w_acc_nxt = w_ovf_nxt ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];

  // Sticky overflow for the block in progress.
  always_ff @(negedge clk) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_acc_clr) begin
      r_ovf <= 1'b0;
    end else if (w_take) begin
      r_ovf <= w_ovf_nxt;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  // Overflow flag published alongside the result.
  always_ff @(negedge clk) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_load) begin
      r_overflow <= w_ovf_nxt;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign overflow = r_overflow;
`else
  assign w_acc_nxt = r_acc + ACC_WIDTH'(in_data);
  assign overflow  = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_ACCUM: begin
        if (clear) begin
          w_state_nxt = ST_IDLE;
        end else if (w_xfer) begin
          if (w_tc) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_ACCUM;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(negedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Running block sum; returns to zero on clear or when a block closes.
  always_ff @(negedge clk) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (w_acc_clr) begin
      r_acc <= '0;
    end else if (w_take) begin
      r_acc <= w_acc_nxt;
    end else begin
      r_acc <= r_acc;
    end
  end

  // Result register and its valid flag.
  always_ff @(negedge clk) begin
    if (!reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_acc_nxt;
      r_out_valid <= 1'b1;
    end else if ((r_state == ST_HOLD) && out_ready) begin
      r_out_data  <= r_out_data;
      r_out_valid <= 1'b0;
    end else begin
      r_out_data  <= r_out_data;
      r_out_valid <= r_out_valid;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sum_accumulator_27bit.sv
// -----------------------------------------------------------------------------
// tb_sum_accumulator_27bit
//   Self-checking bench for sum_accumulator_27bit. Three instances:
//   d0 defaults, d1 ACC_COUNT=4, d2 ACC_WIDTH=28/ACC_COUNT=4.
//   Inputs change on posedge; the DUT updates on negedge; outputs are
//   sampled on posedge. Expected results are queued when stimulus is driven
//   and popped by per-instance monitors when out_valid rises.
// -----------------------------------------------------------------------------
module tb_sum_accumulator_27bit;

  logic clk;
  logic reset;

  logic [26:0] d0_in_data, d1_in_data, d2_in_data;
  logic        d0_in_valid, d1_in_valid, d2_in_valid;
  logic        d0_in_ready, d1_in_ready, d2_in_ready;
  logic        d0_clear, d1_clear, d2_clear;
  logic [31:0] d0_out_data, d1_out_data;
  logic [27:0] d2_out_data;
  logic        d0_out_valid, d1_out_valid, d2_out_valid;
  logic        d0_out_ready, d1_out_ready, d2_out_ready;
  logic        d0_overflow, d1_overflow, d2_overflow;

  logic        d0_prev, d1_prev, d2_prev;
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] q2[$];

  int n_checks = 0;
  int n_errors = 0;

  sum_accumulator_27bit u_d0 (
    .clk(clk), .reset(reset), .in_data(d0_in_data), .in_valid(d0_in_valid),
    .in_ready(d0_in_ready), .clear(d0_clear), .out_data(d0_out_data),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready), .overflow(d0_overflow));

  sum_accumulator_27bit #(.ACC_COUNT(4), .CNT_WIDTH(3)) u_d1 (
    .clk(clk), .reset(reset), .in_data(d1_in_data), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .clear(d1_clear), .out_data(d1_out_data),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .overflow(d1_overflow));

  sum_accumulator_27bit #(.ACC_WIDTH(28), .ACC_COUNT(4), .CNT_WIDTH(3)) u_d2 (
    .clk(clk), .reset(reset), .in_data(d2_in_data), .in_valid(d2_in_valid),
    .in_ready(d2_in_ready), .clear(d2_clear), .out_data(d2_out_data),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .overflow(d2_overflow));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Result monitors: compare each newly presented result with the scoreboard.
  always @(posedge clk) begin : mon0
    logic [32:0] e;
    if (d0_out_valid === 1'b1 && d0_prev === 1'b0) begin
      if (q0.size() == 0) begin
        check_eq("d0_unexpected_result", 64'd1, 64'd0);
      end else begin
        e = q0.pop_front();
        check_eq("d0_data", d0_out_data, e[31:0]);
        check_eq("d0_ovf", d0_overflow, e[32]);
      end
    end
    d0_prev <= d0_out_valid;
  end

  always @(posedge clk) begin : mon1
    logic [32:0] e;
    if (d1_out_valid === 1'b1 && d1_prev === 1'b0) begin
      if (q1.size() == 0) begin
        check_eq("d1_unexpected_result", 64'd1, 64'd0);
      end else begin
        e = q1.pop_front();
        check_eq("d1_data", d1_out_data, e[31:0]);
        check_eq("d1_ovf", d1_overflow, e[32]);
      end
    end
    d1_prev <= d1_out_valid;
  end

  always @(posedge clk) begin : mon2
    logic [32:0] e;
    if (d2_out_valid === 1'b1 && d2_prev === 1'b0) begin
      if (q2.size() == 0) begin
        check_eq("d2_unexpected_result", 64'd1, 64'd0);
      end else begin
        e = q2.pop_front();
        check_eq("d2_data", d2_out_data, e[27:0]);
        check_eq("d2_ovf", d2_overflow, e[32]);
      end
    end
    d2_prev <= d2_out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rsum;
    logic [26:0] rv;

    reset = 1'b0;
    d0_in_data = 27'd5; d0_in_valid = 1'b1; d0_clear = 1'b0; d0_out_ready = 1'b0;
    d1_in_data = 27'd0; d1_in_valid = 1'b0; d1_clear = 1'b0; d1_out_ready = 1'b1;
    d2_in_data = 27'd0; d2_in_valid = 1'b0; d2_clear = 1'b0; d2_out_ready = 1'b1;

    // Test 1: reset held across two negedges with in_valid high.
    repeat (3) @(posedge clk);
    check_eq("t1_out_valid", d0_out_valid, 1'b0);
    check_eq("t1_out_data", d0_out_data, 32'd0);
    check_eq("t1_overflow", d0_overflow, 1'b0);
    check_eq("t1_in_ready", d0_in_ready, 1'b1);
    reset = 1'b1;
    d0_in_valid = 1'b0;

    // Test 2: 16 back-to-back max sums; result exactly after the 16th edge.
    q0.push_back({1'b0, 32'h7FFFFFF0});
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      if (i == 15) check_eq("t2_not_early", d0_out_valid, 1'b0);
      if (i == 8) check_eq("t2_in_ready_accum", d0_in_ready, 1'b1);
      d0_in_valid = 1'b1;
      d0_in_data  = 27'h7FFFFFF;
    end
    @(posedge clk);
    d0_in_valid = 1'b0;
    check_eq("t2_out_valid", d0_out_valid, 1'b1);
    check_eq("t2_overflow", d0_overflow, 1'b0);

    // Test 3: backpressure with in_valid asserted.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      d0_in_valid = 1'b1;
      d0_in_data  = 27'd123;
      check_eq("t3_in_ready_hold", d0_in_ready, 1'b0);
      check_eq("t3_out_data_hold", d0_out_data, 32'h7FFFFFF0);
      check_eq("t3_out_valid_hold", d0_out_valid, 1'b1);
    end
    @(posedge clk);
    d0_in_valid  = 1'b0;
    d0_out_ready = 1'b1;
    @(posedge clk);
    check_eq("t3_out_valid_after", d0_out_valid, 1'b0);
    check_eq("t3_in_ready_after", d0_in_ready, 1'b1);
    check_eq("t3_out_data_kept", d0_out_data, 32'h7FFFFFF0);

    // Random block; clear while holding the result must be ignored.
    d0_out_ready = 1'b0;
    rsum = 32'd0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      rv = 27'($urandom);
      rsum = rsum + {5'd0, rv};
      d0_in_valid = 1'b1;
      d0_in_data  = rv;
    end
    q0.push_back({1'b0, rsum});
    @(posedge clk);
    d0_in_valid = 1'b0;
    check_eq("tr_out_valid", d0_out_valid, 1'b1);
    d0_clear = 1'b1;
    repeat (2) @(posedge clk);
    d0_clear = 1'b0;
    check_eq("tr_clear_in_hold_valid", d0_out_valid, 1'b1);
    check_eq("tr_clear_in_hold_data", d0_out_data, rsum);
    d0_out_ready = 1'b1;
    @(posedge clk);
    check_eq("tr_drained", d0_out_valid, 1'b0);

    // Test 4: clear discards partial block and its same-edge sample.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      d0_in_valid = 1'b1;
      d0_in_data  = 27'd5;
    end
    @(posedge clk);
    d0_clear    = 1'b1;
    d0_in_valid = 1'b1;
    d0_in_data  = 27'd9;
    q0.push_back({1'b0, 32'd16});
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      d0_clear    = 1'b0;
      d0_in_valid = 1'b1;
      d0_in_data  = 27'd1;
    end
    @(posedge clk);
    d0_in_valid = 1'b0;
    check_eq("t4_out_valid", d0_out_valid, 1'b1);
    check_eq("t4_out_data", d0_out_data, 32'd16);

    // Test 5: ACC_COUNT=4 with two idle edges between samples.
    q1.push_back({1'b0, 32'd10});
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      d1_in_valid = 1'b1;
      d1_in_data  = 27'(k);
      if (k < 4) begin
        @(posedge clk);
        d1_in_valid = 1'b0;
        @(posedge clk);
        check_eq("t5_no_early_result", d1_out_valid, 1'b0);
      end
    end
    @(posedge clk);
    d1_in_valid = 1'b0;
    check_eq("t5_out_valid", d1_out_valid, 1'b1);

    // Test 6: ACC_WIDTH=28, four max sums exceed the accumulator range.
`ifdef SUM_ACC_SAT_EN
    q2.push_back({1'b1, 4'd0, 28'hFFFFFFF});
`else
    q2.push_back({1'b0, 4'd0, 28'hFFFFFFC});
`endif
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      d2_in_valid = 1'b1;
      d2_in_data  = 27'h7FFFFFF;
    end
    @(posedge clk);
    d2_in_valid = 1'b0;
    check_eq("t6_out_valid", d2_out_valid, 1'b1);

    repeat (3) @(posedge clk);
    check_eq("q0_empty", q0.size(), 0);
    check_eq("q1_empty", q1.size(), 0);
    check_eq("q2_empty", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
